// File: rtl/btb_pkg.sv
// btb_pkg: shared geometry, field offsets and branch-state encoding for the
// 2-way, 8-set branch target buffer.
//   - Set layout: way1 = set[127:64], way2 = set[63:0].
//   - Way layout: valid[63], tag[62:36], target[35:4], state[3:2], pad[1:0].
package btb_pkg;

    localparam int unsigned NumSets = 8;
    localparam int unsigned NumWays = 2;
    localparam int unsigned WayW    = 64;
    localparam int unsigned SetW    = NumWays * WayW;

    // PC fields used by the lookup.
    localparam int unsigned IdxW   = 3;
    localparam int unsigned IdxLsb = 2;
    localparam int unsigned IdxMsb = IdxLsb + IdxW - 1;
    localparam int unsigned TagLsb = 5;
    localparam int unsigned TagMsb = 31;
    localparam int unsigned TagW   = TagMsb - TagLsb + 1;

    // Field offsets inside one way.
    localparam int unsigned ValidBit = 63;
    localparam int unsigned TagHi    = 62;
    localparam int unsigned TagLo    = 36;
    localparam int unsigned TgtHi    = 35;
    localparam int unsigned TgtLo    = 4;
    localparam int unsigned StHi     = 3;
    localparam int unsigned StLo     = 2;

    typedef enum logic [1:0] {
        StStrongNt = 2'b00,
        StWeakNt   = 2'b01,
        StWeakT    = 2'b10,
        StStrongT  = 2'b11
    } br_state_e;

    // A state predicts taken iff its upper bit is set.
    function automatic logic state_taken(input logic [1:0] st);
        return st[1];
    endfunction

endpackage

// File: rtl/btb_file.sv
// btb_file: the 8 x 128-bit BTB set array plus the 8-bit per-set LRU register.
//   clk, rst            - clock, asynchronous active-high reset (clears everything)
//   we_i/waddr_i        - write enable and set index of the write port
//   wdata_i/wlru_i      - rewritten set and its new LRU bit
//   touch_*_i           - read-side LRU touch port (only with BTB_LOOKUP_LRU_TOUCH_EN)
//   raddr_i/rdata_o     - asynchronous set read
//   lru_o               - current LRU vector
module btb_file
    import btb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [IdxW-1:0] waddr_i,
    input  logic [SetW-1:0] wdata_i,
    input  logic            wlru_i,
`ifdef BTB_LOOKUP_LRU_TOUCH_EN
    input  logic            touch_i,
    input  logic [IdxW-1:0] touch_idx_i,
    input  logic            touch_lru_i,
`endif
    input  logic [IdxW-1:0] raddr_i,
    output logic [SetW-1:0] rdata_o,
    output logic [NumSets-1:0] lru_o
);

    logic [SetW-1:0]    sets_q [NumSets];
    logic [NumSets-1:0] lru_q;
    logic [NumSets-1:0] lru_d;

    always_comb begin
        lru_d = lru_q;
`ifdef BTB_LOOKUP_LRU_TOUCH_EN
        if (touch_i) begin
            lru_d[touch_idx_i] = touch_lru_i;
        end
`endif
        // Applied last so an explicit write beats a touch on the same set.
        if (we_i) begin
            lru_d[waddr_i] = wlru_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NumSets; i++) begin
                sets_q[i] <= '0;
            end
            lru_q <= '0;
        end else begin
            if (we_i) begin
                sets_q[waddr_i] <= wdata_i;
            end
            lru_q <= lru_d;
        end
    end

    assign rdata_o = sets_q[raddr_i];
    assign lru_o   = lru_q;

endmodule

// File: rtl/btb_lookup.sv
// btb_lookup: fetch-side read port of the 2-way, 8-set BTB. Looks up the PC,
// presents a registered prediction one cycle later and forwards the raw set.
//   clk, rst           - clock, asynchronous active-high reset
//   pc_valid, pc       - lookup request and fetch PC (index pc[4:2], tag pc[31:5])
//   stall, flush       - hold prediction registers / kill in-flight prediction
//   upd_*              - write port from the EX-stage update logic
//   pred_*             - registered prediction and set-as-read
//   lru                - current LRU vector
// Optional: define BTB_LOOKUP_LRU_TOUCH_EN to let read hits update the LRU bits.
module btb_lookup
    import btb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_valid,
    input  logic [31:0]        pc,
    input  logic               stall,
    input  logic               flush,
    input  logic               upd_en,
    input  logic [IdxW-1:0]    upd_index,
    input  logic [SetW-1:0]    upd_set,
    input  logic               upd_lru,
    output logic               pred_valid,
    output logic               pred_hit,
    output logic               pred_taken,
    output logic [31:0]        pred_target,
    output logic [SetW-1:0]    pred_set,
    output logic [NumSets-1:0] lru
);

    logic [IdxW-1:0] idx;
    logic [TagW-1:0] tag;
    logic [SetW-1:0] file_rdata;
    logic [SetW-1:0] rd_set;
    logic [WayW-1:0] way1, way2, sel;
    logic            hit1, hit2, hit, taken;
    logic [31:0]     target;

    logic            valid_q, hit_q, taken_q;
    logic [31:0]     target_q;
    logic [SetW-1:0] set_q;

    logic            unused_bits;

    assign idx = pc[IdxMsb:IdxLsb];
    assign tag = pc[TagMsb:TagLsb];

    // Write-first bypass: a same-cycle write to the looked-up set wins over storage.
    assign rd_set = (upd_en && (upd_index == idx)) ? upd_set : file_rdata;
    assign way1   = rd_set[SetW-1:WayW];
    assign way2   = rd_set[WayW-1:0];

    assign hit1   = way1[ValidBit] && (way1[TagHi:TagLo] == tag);
    assign hit2   = way2[ValidBit] && (way2[TagHi:TagLo] == tag);
    assign hit    = hit1 || hit2;
    // way1 takes precedence on a (malformed) double match.
    assign sel    = hit1 ? way1 : way2;
    assign target = hit ? sel[TgtHi:TgtLo] : 32'h0;
    assign taken  = hit && state_taken(sel[StHi:StLo]);

    assign unused_bits = ^{pc[IdxLsb-1:0], sel[StLo-1:0]};

    btb_file u_file (
        .clk         (clk),
        .rst         (rst),
        .we_i        (upd_en),
        .waddr_i     (upd_index),
        .wdata_i     (upd_set),
        .wlru_i      (upd_lru),
`ifdef BTB_LOOKUP_LRU_TOUCH_EN
        // Hit on way1 makes way2 the victim (0), hit on way2 makes way1 the victim (1).
        .touch_i     (pc_valid && hit && !stall),
        .touch_idx_i (idx),
        .touch_lru_i (!hit1),
`endif
        .raddr_i     (idx),
        .rdata_o     (file_rdata),
        .lru_o       (lru)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            hit_q    <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
            set_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
        end else if (!stall) begin
            valid_q  <= pc_valid;
            hit_q    <= pc_valid && hit;
            taken_q  <= pc_valid && taken;
            target_q <= target;
            set_q    <= rd_set;
        end
    end

    assign pred_valid  = valid_q;
    assign pred_hit    = hit_q;
    assign pred_taken  = taken_q;
    assign pred_target = target_q;
    assign pred_set    = set_q;

endmodule
